// File: rtl/pipelined_alu.sv
// Tagged-operand ALU with a valid/ready handshake, an accumulator and a
// multi-cycle signed restoring divider, all behind one registered result port.
module pipelined_alu #(
  parameter int DATA_WIDTH = 16,
  parameter bit DIV_EN     = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            operation,
  input  logic [DATA_WIDTH:0]   op_RHS,
  input  logic [DATA_WIDTH:0]   op_LHS,
  input  logic [DATA_WIDTH:0]   op_SHIFT,
  input  logic [DATA_WIDTH-1:0] op_predicate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  localparam logic [4:0] OP_ADD    = 5'd1;
  localparam logic [4:0] OP_SUB    = 5'd2;
  localparam logic [4:0] OP_MUL    = 5'd3;
  localparam logic [4:0] OP_DIV    = 5'd5;
  localparam logic [4:0] OP_SHL    = 5'd8;
  localparam logic [4:0] OP_LSR    = 5'd9;
  localparam logic [4:0] OP_ASR    = 5'd10;
  localparam logic [4:0] OP_AND    = 5'd11;
  localparam logic [4:0] OP_OR     = 5'd12;
  localparam logic [4:0] OP_XOR    = 5'd13;
  localparam logic [4:0] OP_SEL    = 5'd16;
  localparam logic [4:0] OP_CMERGE = 5'd17;
  localparam logic [4:0] OP_EQ     = 5'd18;
  localparam logic [4:0] OP_LT     = 5'd19;
  localparam logic [4:0] OP_BR     = 5'd20;
  localparam logic [4:0] OP_GT     = 5'd21;
  localparam logic [4:0] OP_ACCUM  = 5'd24;
  localparam logic [4:0] OP_ACCLD  = 5'd25;
  localparam logic [4:0] OP_MOVC   = 5'd31;

  typedef enum logic {IDLE, DIV} state_t;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_rem, r_quo, r_div, r_acc;
  logic          r_neg, r_dbz, r_dovf;
  logic          r_out_valid, r_overflow, r_div_by_zero;
  logic [W-1:0]  r_result;

  logic [4:0]    w_opcode;
  logic [W-1:0]  w_rhs, w_op2, w_rhs_mag, w_op2_mag, w_quo_final, w_result;
  logic [W:0]    w_sum, w_diff, w_acc_sum, w_rem_shift, w_trial;
  logic          w_accept, w_is_div, w_fits, w_ovf, w_unused_tag;

  assign w_opcode     = operation[4:0];
  assign w_rhs        = op_RHS[W-1:0];
  assign w_op2        = operation[5] ? op_SHIFT[W-1:0] : op_LHS[W-1:0];
  assign w_unused_tag = op_SHIFT[W];
  assign w_accept     = in_valid && in_ready;
  assign w_is_div     = DIV_EN && (w_opcode == OP_DIV);

  assign w_sum     = {1'b0, w_rhs} + {1'b0, w_op2};
  assign w_diff    = {1'b0, w_rhs} - {1'b0, w_op2};
  assign w_acc_sum = {1'b0, r_acc} + {1'b0, w_rhs};

  // Divider runs on magnitudes; -MIN_VAL wraps to MIN_VAL, which is the correct unsigned magnitude.
  assign w_rhs_mag   = w_rhs[W-1] ? -w_rhs : w_rhs;
  assign w_op2_mag   = w_op2[W-1] ? -w_op2 : w_op2;
  assign w_rem_shift = {r_rem, r_quo[W-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_div};
  assign w_fits      = !w_trial[W];
  assign w_quo_final = r_neg ? -r_quo : r_quo;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (w_opcode)
      OP_ADD:    {w_ovf, w_result} = w_sum;
      OP_SUB:    {w_ovf, w_result} = w_diff;
      OP_MUL:    w_result = w_rhs * w_op2;
      OP_SHL:    w_result = w_rhs << w_op2;
      OP_LSR:    w_result = w_rhs >> w_op2;
      OP_ASR:    w_result = $unsigned($signed(w_rhs) >>> w_op2);
      OP_AND:    w_result = w_rhs & w_op2;
      OP_OR:     w_result = w_rhs | w_op2;
      OP_XOR:    w_result = w_rhs ^ w_op2;
      OP_SEL: begin
        if (operation[5])   w_result = op_SHIFT[W-1:0];
        else if (op_LHS[W]) w_result = op_LHS[W-1:0];
        else if (op_RHS[W]) w_result = w_rhs;
      end
      OP_CMERGE: w_result = operation[5] ? op_SHIFT[W-1:0] : w_rhs;
      OP_EQ:     w_result = {{(W-1){1'b0}}, w_rhs == w_op2};
      OP_LT:     w_result = {{(W-1){1'b0}}, $signed(w_rhs) < $signed(w_op2)};
      OP_GT:     w_result = {{(W-1){1'b0}}, $signed(w_op2) < $signed(w_rhs)};
      OP_BR:     w_result = op_predicate | w_rhs | w_op2;
      OP_ACCUM:  {w_ovf, w_result} = w_acc_sum;
      OP_ACCLD:  w_result = w_op2;
      OP_MOVC:   w_result = w_op2;
      default:   w_result = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_acc         <= '0;
      r_neg         <= 1'b0;
      r_dbz         <= 1'b0;
      r_dovf        <= 1'b0;
      r_out_valid   <= 1'b0;
      r_result      <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_is_div) begin
            r_state     <= DIV;
            r_count     <= '0;
            r_rem       <= '0;
            r_quo       <= w_rhs_mag;
            r_div       <= w_op2_mag;
            r_neg       <= w_rhs[W-1] ^ w_op2[W-1];
            r_dbz       <= (w_op2 == '0);
            r_dovf      <= (w_rhs == MIN_VAL) && (w_op2 == '1);
            r_out_valid <= 1'b0;
          end else if (w_accept) begin
            r_result      <= w_result;
            r_overflow    <= w_ovf;
            r_div_by_zero <= 1'b0;
            r_out_valid   <= 1'b1;
            if (w_opcode == OP_ACCUM || w_opcode == OP_ACCLD) r_acc <= w_result;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        DIV: begin
          if (r_count == CW'(W)) begin
            r_state       <= IDLE;
            r_result      <= r_dbz ? '1 : w_quo_final;
            r_overflow    <= r_dovf;
            r_div_by_zero <= r_dbz;
            r_out_valid   <= 1'b1;
          end else begin
            r_count <= r_count + CW'(1);
            r_rem   <= w_fits ? w_trial[W-1:0] : w_rem_shift[W-1:0];
            r_quo   <= {r_quo[W-2:0], w_fits};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE) && (!r_out_valid || out_ready);
  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign overflow    = r_overflow;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: doc/pipelined_alu.md
PIPELINED_ALU -- requirements
Module: pipelined_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the datapath width in bits (minimum 4).
REQ-002 The block SHALL have parameter DIV_EN, default 1; when 0, divide SHALL be treated as an unsupported opcode.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operation is presented.
REQ-006 The block SHALL have port in_ready, output, 1 bit: an operation can be accepted.
REQ-007 The block SHALL have port operation, input, 6 bits: bit 5 selects op_2 (1 = op_SHIFT, 0 = op_LHS); bits 4:0 are the opcode.
REQ-008 The block SHALL have ports op_RHS, op_LHS and op_SHIFT, each input, DATA_WIDTH+1 bits: the operands, with the MSB as the valid/predicate tag.
REQ-009 The block SHALL have port op_predicate, input, DATA_WIDTH bits: the predicate operand for br.
REQ-010 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port result, output, DATA_WIDTH bits: the registered result.
REQ-013 The block SHALL have port overflow, output, 1 bit: carry/borrow out of add, sub and accum.
REQ-014 The block SHALL have port div_by_zero, output, 1 bit: a divide was issued with a zero divisor.

Function
REQ-015 An input transfer SHALL occur on a clock edge where in_valid and in_ready are both high; an output transfer SHALL occur on an edge where out_valid and out_ready are both high.
REQ-016 in_ready SHALL equal (state==IDLE) and (out_valid==0 or out_ready==1).
REQ-017 The FSM SHALL have states IDLE and DIV: IDLE->DIV on accepting divide with DIV_EN=1; DIV->IDLE when the iteration count reaches DATA_WIDTH.
REQ-018 Single-cycle ops accepted at edge N SHALL produce out_valid=1 with result, overflow and div_by_zero from edge N+1.
REQ-019 result, overflow and div_by_zero SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 out_valid SHALL clear after an output transfer unless a new result is loaded on the same edge.
REQ-021 Opcodes SHALL behave as follows, with op_2 per REQ-007 and operands using bits DATA_WIDTH-1:0:
- 0: nop, result 0.
- 1: add, {overflow,result} = RHS+op_2.
- 2: sub, {overflow,result} = RHS-op_2.
- 3: signed mul, low DATA_WIDTH bits.
- 8/9/10: shift left / logical right / arithmetic right of RHS by op_2.
- 11/12/13: and / or / xor.
- 18: eq.
- 19: signed RHS<op_2.
- 21: signed op_2<RHS.
- 20: br, predicate|RHS|op_2.
- 31: movc, op_2.
REQ-022 Opcode 16 (select) with bit5=0 SHALL return LHS if its tag is set, else RHS if its tag is set, else 0; with bit5=1 it SHALL return op_SHIFT. Opcode 17 (cmerge) SHALL return RHS when bit5=0 and op_SHIFT when bit5=1.
REQ-023 Opcode 5 SHALL be signed restoring division of RHS by op_2, one quotient bit per cycle, truncating toward zero, with the remainder discarded.
REQ-024 A divide accepted at edge N SHALL assert out_valid at edge N+DATA_WIDTH+1, with in_ready=0 throughout.
REQ-025 A divide with divisor 0 SHALL return an all-ones result with div_by_zero=1, at the same latency as REQ-024.
REQ-026 The most-negative dividend divided by -1 SHALL return the most-negative value with overflow=1.
REQ-027 The internal DATA_WIDTH-bit accumulator acc SHALL be updated as follows:
- Opcode 24 (accum): acc <= acc+RHS, result = new acc, overflow = carry.
- Opcode 25 (acc load): acc <= op_2, result = op_2.
REQ-028 Unsupported opcodes SHALL complete in one cycle with result 0 and flags 0.
REQ-029 Flags SHALL be 0 for every opcode that does not define them.

Reset
REQ-030 While resetn=0, the block SHALL drive out_valid=0, result=0, overflow=0, div_by_zero=0, acc=0 and state=IDLE, and in_ready SHALL read 1 after release.
REQ-031 Reset asserted during DIV SHALL abort the divide, and no result for it SHALL ever be emitted.

Verification
REQ-032 With DATA_WIDTH=16 and out_ready=1, add 0xFFFF+0x0001 SHALL give result 0x0000 and overflow=1, with out_valid one cycle after accept.
REQ-033 Divide -100/7 SHALL give result 0xFFF2; in_ready SHALL be low for 17 cycles and out_valid SHALL be high at accept+17.
REQ-034 Divide 5/0 SHALL give result 0xFFFF with div_by_zero=1; divide 0x8000/0xFFFF SHALL give 0x8000 with overflow=1.
REQ-035 With out_ready=0 for 3 cycles after an add 3+4, the bench SHALL check:
- result stays 7 and in_ready stays 0.
- A second add 1+1 is accepted on the drain edge and yields 2 on the next cycle.
REQ-036 Acc load 10, then accum 5, then accum 7 SHALL give results 10, 15, 22.
REQ-037 resetn pulsed low at cycle 5 of a divide SHALL give out_valid=0 and acc=0, and the next add 2+2 SHALL return 4.
